// File: rtl/fetch_pkg.sv
// Shared constants and types for the pipelined instruction fetch unit.
// Holds the branch immediate field layout, the PC step and the instruction-queue entry layout.
package fetch_pkg;

    localparam int unsigned IMM26_LSB = 0;
    localparam int unsigned IMM26_W   = 26;
    localparam int unsigned IMM19_LSB = 5;
    localparam int unsigned IMM19_W   = 19;
    localparam int unsigned PC_INC    = 4;

    localparam int unsigned ENTRY_INSTR_W = 32;
    localparam int unsigned ENTRY_PC_W    = 64;

    // Queue entry: instruction word in the upper bits, its PC in the lower bits.
    typedef struct packed {
        logic [ENTRY_INSTR_W-1:0] instr;
        logic [ENTRY_PC_W-1:0]    pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Power-of-two circular instruction queue with occupancy count and a flush.
// The flush has priority over push and pop in the same cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 96,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage needs no reset; only entries covered by count are ever read.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign valid = (count != '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/pipelined_fetch.sv
// Instruction fetch front end: credit-limited request issue, in-order response tracking,
// redirect with drop counting for stale responses, and a decode-side instruction queue.
module pipelined_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 64,
    parameter int unsigned        INSTR_W  = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic               redirect_uncond,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic [INSTR_W-1:0] redirect_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc
);

    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);
    localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  resp_pc;
    logic [CNT_W-1:0]   outstanding;
    logic [CNT_W-1:0]   outstanding_next;
    logic [CNT_W-1:0]   drop_cnt;
    logic [CNT_W-1:0]   occupancy;
    logic [CNT_W:0]     credit_used;
    logic               grant;
    logic               push;
    logic [ENTRY_W-1:0] head;

    logic [IMM26_W-1:0] imm26;
    logic [IMM19_W-1:0] imm19;
    logic [ADDR_W-1:0]  offset;
    logic [ADDR_W-1:0]  target;
    logic               unused_instr_bits;

    // Branch target from the selected, sign-extended, word-scaled immediate.
    assign imm26 = redirect_instr[IMM26_LSB +: IMM26_W];
    assign imm19 = redirect_instr[IMM19_LSB +: IMM19_W];
    assign unused_instr_bits = ^redirect_instr[INSTR_W-1:IMM26_LSB+IMM26_W];

    always_comb begin
        offset = '0;
        if (redirect_uncond) offset = {{(ADDR_W-IMM26_W-2){imm26[IMM26_W-1]}}, imm26, 2'b00};
        else                 offset = {{(ADDR_W-IMM19_W-2){imm19[IMM19_W-1]}}, imm19, 2'b00};
        target = redirect_pc + offset;
    end

    // Queued plus in-flight words never exceed DEPTH, so the queue cannot overflow.
    assign credit_used = {1'b0, occupancy} + {1'b0, outstanding};
    assign imem_req    = !reset && !redirect && (credit_used < (CNT_W+1)'(DEPTH));
    assign imem_addr   = fetch_pc;
    assign grant       = imem_req && imem_gnt;

    assign outstanding_next = outstanding + CNT_W'(grant) - CNT_W'(imem_rvalid);
    assign push = imem_rvalid && !redirect && (drop_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (redirect) begin
                // Everything still in flight belongs to the abandoned path.
                fetch_pc <= target;
                resp_pc  <= target;
                drop_cnt <= outstanding_next;
            end else begin
                if (grant) fetch_pc <= fetch_pc + ADDR_W'(PC_INC);
                if (imem_rvalid) begin
                    if (drop_cnt != '0) drop_cnt <= drop_cnt - CNT_W'(1);
                    else                resp_pc  <= resp_pc + ADDR_W'(PC_INC);
                end
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data ({imem_rdata, resp_pc}),
        .pop       (out_ready),
        .valid     (out_valid),
        .head      (head),
        .count     (occupancy)
    );

    assign out_instr = head[ENTRY_W-1 -: INSTR_W];
    assign out_pc    = head[ADDR_W-1:0];

endmodule

// File: tb/tb_pipelined_fetch.sv
// Scoreboard bench for pipelined_fetch: an in-order memory model with programmable latency,
// directed stimulus that queues expected {instr, pc} pairs, and a monitor that checks every pop.
module tb_pipelined_fetch;
    import fetch_pkg::*;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned INSTR_W = 32;

    logic               clk = 1'b0;
    logic               reset;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic               redirect_uncond;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [INSTR_W-1:0] redirect_instr;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    always #5 clk = ~clk;

    pipelined_fetch #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .DEPTH    (4),
        .RESET_PC ('0)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_uncond (redirect_uncond),
        .redirect_pc     (redirect_pc),
        .redirect_instr  (redirect_instr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        int                due;
    } pend_t;

    pend_t        pend[$];
    fetch_entry_t exp_q[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int lat   = 1;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return 32'hC0DE_0000 ^ a[31:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic expect_pc(input logic [63:0] pc);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = instr_of(pc);
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Grant exactly n requests, starting at the current cycle.
    task automatic grant_n(input int n);
        int k = 0;
        imem_gnt = 1'b1;
        for (int c = 0; c < 200 && k < n; c++) begin
            @(negedge clk);
            if (imem_req && imem_gnt) k++;
            next_cycle();
        end
        imem_gnt = 1'b0;
        check("grant_count", 64'(k), 64'(n));
    endtask

    task automatic wait_empty(input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) next_cycle();
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    // Memory: record grants, return words in order after lat cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && imem_req && imem_gnt) begin
                pend_t p;
                p.addr = imem_addr;
                p.due  = cyc + lat;
                pend.push_back(p);
            end
        end
    end

    initial begin
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        forever begin
            next_cycle();
            cyc++;
            if (reset) begin
                pend.delete();
                imem_rvalid = 1'b0;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rvalid = 1'b0;
            end
        end
    end

    // Monitor: every handshake must match the next expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got pc %h want none", out_pc);
                end else begin
                    fetch_entry_t e;
                    e = exp_q.pop_front();
                    check("out_pc", out_pc, e.pc);
                    check("out_instr", 64'(out_instr), 64'(e.instr));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int g;
        reset = 1'b1;
        imem_gnt = 1'b1;
        redirect = 1'b0;
        redirect_uncond = 1'b0;
        redirect_pc = '0;
        redirect_instr = '0;
        out_ready = 1'b1;

        // Reset state and first-word latency.
        repeat (3) next_cycle();
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_imem_req", 64'(imem_req), 64'd0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("first_req", 64'(imem_req), 64'd1);
        check("first_addr", imem_addr, 64'h0);
        check("lat_c0_valid", 64'(out_valid), 64'd0);
        next_cycle();
        imem_gnt = 1'b0;
        expect_pc(64'h0);
        @(negedge clk);
        check("lat_c1_valid", 64'(out_valid), 64'd0);
        next_cycle();
        @(negedge clk);
        check("lat_c2_valid", 64'(out_valid), 64'd1);

        // Streaming fetch, 1-cycle memory.
        next_cycle();
        for (int i = 1; i <= 8; i++) expect_pc(64'(4 * i));
        grant_n(8);
        wait_empty(40);

        // Back-pressure: credit stops at DEPTH, one pop frees one request.
        out_ready = 1'b0;
        imem_gnt  = 1'b1;
        g = 0;
        repeat (12) begin
            @(negedge clk);
            if (imem_req && imem_gnt) g++;
            next_cycle();
        end
        check("credit_grants", 64'(g), 64'd4);
        for (int i = 0; i < 4; i++) expect_pc(64'(36 + 4 * i));
        @(negedge clk);
        check("full_req", 64'(imem_req), 64'd0);
        next_cycle();
        out_ready = 1'b1;
        @(negedge clk);
        check("pop_cycle_req", 64'(imem_req), 64'd0);
        next_cycle();
        out_ready = 1'b0;
        @(negedge clk);
        check("req_after_pop", 64'(imem_req), 64'd1);
        expect_pc(64'h34);
        next_cycle();
        imem_gnt  = 1'b0;
        out_ready = 1'b1;
        wait_empty(40);

        // Unconditional redirect flushes a full queue: 0x100 + (-2 << 2) = 0xF8.
        out_ready = 1'b0;
        imem_gnt  = 1'b1;
        repeat (6) next_cycle();
        imem_gnt = 1'b0;
        @(negedge clk);
        check("pre_flush_valid", 64'(out_valid), 64'd1);
        next_cycle();
        redirect = 1'b1;
        redirect_uncond = 1'b1;
        redirect_pc = 64'h100;
        redirect_instr = 32'h03FF_FFFE;
        @(negedge clk);
        check("redirect_req", 64'(imem_req), 64'd0);
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        check("tgt_uncond", imem_addr, 64'hF8);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("post_redirect_req", 64'(imem_req), 64'd1);
        expect_pc(64'hF8);
        expect_pc(64'hFC);
        expect_pc(64'h100);
        next_cycle();
        grant_n(3);
        out_ready = 1'b1;
        wait_empty(40);

        // Latency 4: redirect with 3 in flight, then a second redirect while still dropping.
        lat = 4;
        imem_gnt = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        imem_gnt = 1'b0;
        redirect = 1'b1;
        redirect_uncond = 1'b0;
        redirect_pc = 64'h0;
        redirect_instr = 32'h00FF_FFE0;
        @(negedge clk);
        check("cond_redirect_req", 64'(imem_req), 64'd0);
        next_cycle();
        redirect = 1'b0;
        imem_gnt = 1'b1;
        @(negedge clk);
        check("tgt_cond", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        check("drop_valid", 64'(out_valid), 64'd0);
        next_cycle();
        imem_gnt = 1'b0;
        redirect = 1'b1;
        redirect_pc = 64'h2000;
        redirect_instr = 32'h0000_0080;
        next_cycle();
        redirect = 1'b0;
        imem_gnt = 1'b1;
        @(negedge clk);
        check("tgt_accum", imem_addr, 64'h2010);
        next_cycle();
        next_cycle();
        imem_gnt = 1'b0;
        expect_pc(64'h2010);
        expect_pc(64'h2014);
        wait_empty(40);

        // Pop in the redirect cycle consumes the head once; the rest is flushed.
        lat = 1;
        out_ready = 1'b0;
        grant_n(2);
        next_cycle();
        next_cycle();
        expect_pc(64'h2018);
        out_ready = 1'b1;
        redirect = 1'b1;
        redirect_uncond = 1'b1;
        redirect_pc = 64'h100;
        redirect_instr = 32'h03FF_FFFE;
        next_cycle();
        redirect = 1'b0;
        @(negedge clk);
        check("pop_flush_valid", 64'(out_valid), 64'd0);
        check("pop_flush_addr", imem_addr, 64'hF8);
        expect_pc(64'hF8);
        next_cycle();
        grant_n(1);
        wait_empty(40);

        // Asynchronous reset mid-burst.
        out_ready = 1'b0;
        imem_gnt  = 1'b1;
        repeat (3) next_cycle();
        @(negedge clk);
        check("burst_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #3;
        reset = 1'b1;
        imem_gnt = 1'b0;
        #1;
        check("async_valid", 64'(out_valid), 64'd0);
        check("async_req", 64'(imem_req), 64'd0);
        pend.delete();
        imem_rvalid = 1'b0;
        repeat (2) next_cycle();
        reset = 1'b0;
        @(negedge clk);
        check("restart_addr", imem_addr, 64'h0);
        check("restart_req", 64'(imem_req), 64'd1);
        expect_pc(64'h0);
        out_ready = 1'b1;
        next_cycle();
        grant_n(1);
        wait_empty(20);

        repeat (3) next_cycle();
        @(negedge clk);
        check("final_valid", 64'(out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
